// File: rtl/fila_pkg.sv
// Shared widths and state encoding for the byte queue and its consumer.
package fila_pkg;

  localparam int DATA_W     = 8;
  localparam int LEN_W      = 8;
  localparam int FILA_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CAPT,
    OUT
  } leitor_state_t;

endpackage

// File: rtl/leitor_fila.sv
// Queue consumer: pulses dequeue, captures the head byte, offers it on a valid/ready
// port, then waits for the queue occupancy to settle before the next request.
module leitor_fila
  import fila_pkg::*;
#(
  parameter int DATA_W_P      = DATA_W,
  parameter int LEN_W_P       = LEN_W,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk_10KHz,
  input  logic                reset,
  input  logic                enable,
  input  logic [LEN_W_P-1:0]  len_in,
  input  logic [DATA_W_P-1:0] data_in,
  output logic                dequeue_out,
  output logic [DATA_W_P-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LEN_W_P-1:0]  consumed_count,
  output logic                busy
);

  localparam logic [2:0] SETTLE_INIT = 3'(SETTLE_CYCLES);

  leitor_state_t       state_q, state_d;
  logic [2:0]          settle_q, settle_d;
  logic [DATA_W_P-1:0] data_q, data_d;
  logic [LEN_W_P-1:0]  count_q, count_d;

  // NOTE: every variable gets its hold value before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d  = state_q;
    settle_d = (settle_q != 3'd0) ? settle_q - 3'd1 : settle_q;
    data_d   = data_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        // Settle delay lets the queue's occupancy catch up after the last pop.
        if (enable && (len_in != '0) && (settle_q == 3'd0)) state_d = REQ;
      end
      REQ:  state_d = CAPT;
      CAPT: begin
        data_d   = data_in;
        settle_d = SETTLE_INIT;
        state_d  = OUT;
      end
      OUT: begin
        if (out_ready) begin
          count_d = count_q + LEN_W_P'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      settle_q <= 3'd0;
      data_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      data_q   <= data_d;
      count_q  <= count_d;
    end
  end

  // Moore outputs decoded from the state register, so reset clears them at once.
  assign dequeue_out    = (state_q == REQ);
  assign out_valid      = (state_q == OUT);
  assign out_data       = data_q;
  assign consumed_count = count_q;
  assign busy           = (state_q != IDLE) || (settle_q != 3'd0);

endmodule

// File: tb/tb_leitor_fila.sv
// Directed bench for leitor_fila with a behavioural 8-entry queue on its read side.
`timescale 1ns/1ps
module tb_leitor_fila;
  import fila_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, enable, out_ready;
  logic              dequeue_out, out_valid, busy;
  logic [LEN_W-1:0]  len_in, consumed_count;
  logic [DATA_W-1:0] data_in, out_data;
  logic              push_en;
  logic [7:0]        push_byte;

  int checks   = 0;
  int failures = 0;

  leitor_fila #(.SETTLE_CYCLES(2)) dut (
    .clk_10KHz      (clk),
    .reset          (reset),
    .enable         (enable),
    .len_in         (len_in),
    .data_in        (data_in),
    .dequeue_out    (dequeue_out),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .consumed_count (consumed_count),
    .busy           (busy)
  );

  // Queue model: head byte registered on the dequeue edge, occupancy registered.
  logic [7:0] fila[$];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fila.delete();
      len_in  <= '0;
      data_in <= '0;
    end else begin
      if (dequeue_out && fila.size() > 0) data_in <= fila.pop_front();
      if (push_en) fila.push_back(push_byte);
      len_in <= LEN_W'(fila.size());
    end
  end

  // Monitors: delivered bytes with edge stamps, pulse statistics.
  int         cyc = 0;
  logic [7:0] got_data[$];
  int         got_cyc[$];
  int         deq_rises = 0, deq_high = 0, bad_pulse = 0;
  int         last_req = 0, last_val = 0;
  logic       prev_deq = 1'b0, prev_val = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_cyc.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    prev_deq <= dequeue_out;
    prev_val <= out_valid;
    if (dequeue_out) begin
      deq_high <= deq_high + 1;
      if (!prev_deq) begin
        deq_rises <= deq_rises + 1;
        last_req  <= cyc;
      end
      if (len_in == '0) bad_pulse <= bad_pulse + 1;
    end
    if (out_valid && !prev_val) last_val <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    push_byte = b;
    push_en   = 1'b1;
    @(negedge clk);
    push_en   = 1'b0;
  endtask

  task automatic wait_deliv(input int target, input int budget, input string tag);
    int n = 0;
    while (got_data.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(got_data.size() >= target), 1);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 1);
  endtask

  initial begin
    int   bd, br, bh, n, errs, tmo;
    logic stable;

    reset = 1'b1; enable = 1'b0; out_ready = 1'b0;
    push_en = 1'b0; push_byte = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_deq",   32'(dequeue_out), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data",  32'(out_data), 0);
    check("rst_count", 32'(consumed_count), 0);
    check("rst_busy",  32'(busy), 0);

    // Drain three bytes
    bd = got_data.size(); br = deq_rises; bh = deq_high;
    push(8'h11); push(8'h22); push(8'h33);
    enable = 1'b1; out_ready = 1'b1;
    wait_deliv(bd + 3, 60, "drain3");
    repeat (6) @(negedge clk);
    check("d3_byte0", 32'(got_data[bd]),   'h11);
    check("d3_byte1", 32'(got_data[bd+1]), 'h22);
    check("d3_byte2", 32'(got_data[bd+2]), 'h33);
    check("d3_gap01", 32'(got_cyc[bd+1] - got_cyc[bd]),   5);
    check("d3_gap12", 32'(got_cyc[bd+2] - got_cyc[bd+1]), 5);
    check("d3_pulses", 32'(deq_rises - br), 3);
    check("d3_pulse_width", 32'(deq_high - bh), 3);
    check("d3_count", 32'(consumed_count), 3);
    check("d3_len",   32'(len_in), 0);
    check("d3_busy",  32'(busy), 0);
    check("latency",  32'(last_val - last_req), 2);

    // Back-pressure
    enable = 1'b0; out_ready = 1'b0;
    push(8'hA5); push(8'h5A);
    bd = got_data.size(); br = deq_rises;
    enable = 1'b1;
    wait_valid(20, "bp");
    check("bp_data", 32'(out_data), 'hA5);
    check("bp_busy", 32'(busy), 1);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || out_data !== 8'hA5) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 1);
    check("bp_pulses", 32'(deq_rises - br), 1);
    check("bp_no_deliv", 32'(got_data.size() - bd), 0);
    out_ready = 1'b1;
    wait_deliv(bd + 2, 40, "bp");
    check("bp_byte0", 32'(got_data[bd]),   'hA5);
    check("bp_byte1", 32'(got_data[bd+1]), 'h5A);
    check("bp_count", 32'(consumed_count), 5);
    repeat (5) @(negedge clk);

    // Asynchronous reset while holding A5 in OUT
    enable = 1'b0; out_ready = 1'b0;
    push(8'hA5);
    enable = 1'b1;
    wait_valid(20, "mr");
    check("mr_data_before", 32'(out_data), 'hA5);
    br = deq_rises;
    reset = 1'b1;
    #1;
    check("mr_valid", 32'(out_valid), 0);
    check("mr_data",  32'(out_data), 0);
    check("mr_count", 32'(consumed_count), 0);
    check("mr_busy",  32'(busy), 0);
    check("mr_deq",   32'(dequeue_out), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mr_no_pulse", 32'(deq_rises - br), 0);
    check("mr_valid_after", 32'(out_valid), 0);

    // Enable gating
    enable = 1'b0; out_ready = 1'b1;
    bd = got_data.size(); br = deq_rises;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    repeat (20) @(negedge clk);
    check("eg_no_pulse", 32'(deq_rises - br), 0);
    check("eg_len", 32'(len_in), 4);
    enable = 1'b1;
    n = 0;
    while (!dequeue_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("eg_req", 32'(dequeue_out), 1);
    @(negedge clk);
    enable = 1'b0;
    wait_deliv(bd + 1, 20, "eg");
    repeat (20) @(negedge clk);
    check("eg_byte",   32'(got_data[bd]), 'hC1);
    check("eg_pulses", 32'(deq_rises - br), 1);
    check("eg_len_after", 32'(len_in), 3);
    check("eg_count",  32'(consumed_count), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 32 full queues: 256 bytes, count wraps to 0
    bd = got_data.size(); br = deq_rises; bh = deq_high;
    enable = 1'b1; out_ready = 1'b1;
    tmo = 0;
    for (int r = 0; r < 32; r++) begin
      for (int i = 0; i < FILA_DEPTH; i++) push(8'(r * FILA_DEPTH + i));
      n = 0;
      while (!(len_in == '0 && !busy) && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) tmo++;
      if (r == 30) check("wrap_count_248", 32'(consumed_count), 248);
    end
    check("wrap_timeouts", 32'(tmo), 0);
    check("wrap_delivered", 32'(got_data.size() - bd), 256);
    errs = 0;
    for (int k = 0; k < 256; k++)
      if (got_data[bd+k] !== 8'(k)) errs++;
    check("wrap_order", 32'(errs), 0);
    check("wrap_count", 32'(consumed_count), 0);
    check("wrap_pulses", 32'(deq_rises - br), 256);
    check("wrap_pulse_width", 32'(deq_high - bh), 256);
    check("empty_pulses", 32'(bad_pulse), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
